// File: rtl/div_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_if
// Purpose  : Request/result bundle between the execute stage and div_iter.
// Revision : 1.0 - initial release
// ============================================================================
interface div_iter_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] opr_a_i;
    logic [XLEN-1:0] opr_b_i;
    logic            div_instr_i;
    logic [1:0]      div_func_i;
    logic            word_op_i;
    logic            flush_i;
    logic            kill_i;
    logic [XLEN-1:0] div_res_o;
    logic            valid_res_o;
    logic            div_busy_o;

    modport master (
        output opr_a_i, opr_b_i, div_instr_i, div_func_i, word_op_i, flush_i, kill_i,
        input  div_res_o, valid_res_o, div_busy_o
    );

    modport slave (
        input  opr_a_i, opr_b_i, div_instr_i, div_func_i, word_op_i, flush_i, kill_i,
        output div_res_o, valid_res_o, div_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU + word ops).
//            Optional macro DIV_EARLY_OUT_EN: 1-cycle path when |a| < |b|.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic      clk,
    input  logic      reset,
    div_iter_if.slave dif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                 c_cnt_w     = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_last_full = c_cnt_w'(XLEN - 1);
    localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(31);
    localparam logic [XLEN-1:0]    c_min_word  = XLEN'(64'h8000_0000);
    localparam logic [XLEN-1:0]    c_min_full  = {1'b1, {(XLEN-1){1'b0}}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_quot;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_div;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_word;
    logic               r_rem_sel;

    logic               w_abort;
    logic               w_accept;
    logic               w_word;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_early;
    logic               w_special;
    logic               w_valid;
    logic [XLEN-1:0]    w_a_ext;
    logic [XLEN-1:0]    w_b_ext;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;
    logic [XLEN-1:0]    w_q_fix;
    logic [XLEN-1:0]    w_r_fix;
    logic [XLEN-1:0]    w_sel;
    logic [XLEN-1:0]    w_res;

    // Operand conditioning: extend word operands, then split into sign + magnitude
    always_comb begin
        w_word   = (WORD_OPS != 0) && dif.word_op_i;
        w_signed = ~dif.div_func_i[0];
        if (w_word) begin
            w_a_ext = w_signed ? XLEN'($signed(dif.opr_a_i[31:0])) : XLEN'(dif.opr_a_i[31:0]);
            w_b_ext = w_signed ? XLEN'($signed(dif.opr_b_i[31:0])) : XLEN'(dif.opr_b_i[31:0]);
        end else begin
            w_a_ext = dif.opr_a_i;
            w_b_ext = dif.opr_b_i;
        end
        w_a_neg  = w_signed && w_a_ext[XLEN-1];
        w_b_neg  = w_signed && w_b_ext[XLEN-1];
        w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
        w_b_zero = (w_b_ext == '0);
        w_ovf    = w_a_neg && (w_b_ext == '1) &&
                   (w_a_mag == (w_word ? c_min_word : c_min_full));
`ifdef DIV_EARLY_OUT_EN
        w_early  = !w_b_zero && (w_a_mag < w_b_mag);
`else
        w_early  = 1'b0;
`endif
        w_special = w_b_zero || w_ovf || w_early;
        w_abort   = dif.flush_i || dif.kill_i;
        w_accept  = (r_state == IDLE) && dif.div_instr_i && !w_abort;
    end

    always_comb begin
        w_shift = {r_rem, r_quot[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_div};
        w_q_fix = r_q_neg ? -r_quot : r_quot;
        w_r_fix = r_r_neg ? -r_rem : r_rem;
        w_sel   = r_rem_sel ? w_r_fix : w_q_fix;
        w_res   = r_word ? XLEN'($signed(w_sel[31:0])) : w_sel;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_special ? DONE : CALC;
            CALC: if (r_cnt == '0) w_state_nxt = DONE;
            DONE: begin
                w_state_nxt = IDLE;
                w_valid     = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_valid     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_word    <= 1'b0;
            r_rem_sel <= 1'b0;
        end else if (w_accept) begin
            r_word    <= w_word;
            r_rem_sel <= dif.div_func_i[1];
            r_div     <= w_b_mag;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            r_cnt     <= w_word ? c_last_word : c_last_full;
            r_rem     <= '0;
            // Word dividends are left-aligned so the MSB feeds the shifter first
            r_quot    <= w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
            if (w_b_zero) begin
                r_quot  <= '1;
                r_rem   <= w_a_mag;
                r_q_neg <= 1'b0;
            end else if (w_ovf) begin
                r_quot  <= w_a_ext;
                r_q_neg <= 1'b0;
            end else if (w_early) begin
                r_quot  <= '0;
                r_rem   <= w_a_mag;
            end
        end else if (r_state == CALC) begin
            r_rem  <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], ~w_diff[XLEN]};
            r_cnt  <= r_cnt - c_cnt_w'(1);
        end
    end

    assign dif.valid_res_o = w_valid;
    assign dif.div_res_o   = w_valid ? w_res : '0;
    assign dif.div_busy_o  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Purpose  : Directed self-checking bench for div_iter (XLEN=64, WORD_OPS=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;
    localparam int         XLEN   = 64;
    localparam logic [1:0] F_DIV  = 2'b00;
    localparam logic [1:0] F_DIVU = 2'b01;
    localparam logic [1:0] F_REM  = 2'b10;
    localparam logic [1:0] F_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
    localparam int         EO_LAT = 1;
`else
    localparam int         EO_LAT = 65;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic bok;
    logic seen;

    div_iter_if #(.XLEN(XLEN)) dif ();

    div_iter #(.XLEN(XLEN), .WORD_OPS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] f, input logic w);
        @(negedge clk);
        dif.opr_a_i     = a;
        dif.opr_b_i     = b;
        dif.div_func_i  = f;
        dif.word_op_i   = w;
        dif.div_instr_i = 1'b1;
        @(posedge clk);
        #1;
        dif.div_instr_i = 1'b0;
    endtask

    task automatic wait_valid(output int l, output logic busy_ok);
        l       = 1;
        busy_ok = 1'b1;
        while (dif.valid_res_o !== 1'b1 && l < 200) begin
            if (dif.div_busy_o !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            l++;
        end
        if (dif.div_busy_o !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] f, input logic w,
                          input logic [63:0] exp_res, input int exp_lat);
        int   l;
        logic bo;
        start(a, b, f, w);
        wait_valid(l, bo);
        chk({tag, " res"}, dif.div_res_o, exp_res);
        chk({tag, " lat"}, 64'(l), 64'(exp_lat));
        chk({tag, " busy"}, {63'b0, bo}, 64'd1);
        @(posedge clk);
        #1;
        chk({tag, " strobe"}, {63'b0, dif.valid_res_o}, 64'd0);
        chk({tag, " idle"}, {63'b0, dif.div_busy_o}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        dif.opr_a_i     = '0;
        dif.opr_b_i     = '0;
        dif.div_instr_i = 1'b0;
        dif.div_func_i  = 2'b00;
        dif.word_op_i   = 1'b0;
        dif.flush_i     = 1'b0;
        dif.kill_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", {63'b0, dif.valid_res_o}, 64'd0);
        chk("reset busy", {63'b0, dif.div_busy_o}, 64'd0);
        chk("reset res", dif.div_res_o, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("div 100/-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("rem 100/-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, F_REM, 1'b0, 64'd2, 65);
        run_op("divuw", 64'hFFFF_FFFF_0000_0010, 64'd3, F_DIVU, 1'b1, 64'd5, 33);
        run_op("remw -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, F_REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divw -20/3", 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, F_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 33);
        run_op("divu by 0", 64'd42, 64'd0, F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu by 0", 64'd42, 64'd0, F_REMU, 1'b0, 64'd42, 1);
        run_op("div ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, F_DIV, 1'b0, 64'h8000_0000_0000_0000, 1);
        run_op("rem ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, F_REM, 1'b0, 64'd0, 1);
        run_op("divw ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, F_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);

        // Flush partway through an operation
        start(64'd1000, 64'd7, F_DIVU, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            if (dif.valid_res_o !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("flush pre busy", {63'b0, dif.div_busy_o}, 64'd1);
        @(negedge clk);
        dif.flush_i = 1'b1;
        @(posedge clk);
        #1;
        dif.flush_i = 1'b0;
        chk("flush busy drop", {63'b0, dif.div_busy_o}, 64'd0);
        repeat (70) begin
            if (dif.valid_res_o !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("flush no valid", {63'b0, seen}, 64'd0);
        run_op("divu 9/3 after flush", 64'd9, 64'd3, F_DIVU, 1'b0, 64'd3, 65);

        // Request coincident with flush in IDLE must be dropped
        @(negedge clk);
        dif.opr_a_i     = 64'd50;
        dif.opr_b_i     = 64'd5;
        dif.div_func_i  = F_DIVU;
        dif.word_op_i   = 1'b0;
        dif.div_instr_i = 1'b1;
        dif.flush_i     = 1'b1;
        @(posedge clk);
        #1;
        dif.div_instr_i = 1'b0;
        dif.flush_i     = 1'b0;
        chk("flush+instr busy", {63'b0, dif.div_busy_o}, 64'd0);
        chk("flush+instr valid", {63'b0, dif.valid_res_o}, 64'd0);

        // New request while busy is ignored
        start(64'd100, 64'd10, F_DIVU, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        dif.opr_a_i     = 64'd7;
        dif.opr_b_i     = 64'd1;
        dif.div_func_i  = F_REMU;
        dif.div_instr_i = 1'b1;
        @(posedge clk);
        #1;
        dif.div_instr_i = 1'b0;
        wait_valid(lat, bok);
        chk("busy ignore res", dif.div_res_o, 64'd10);
        chk("busy ignore lat", 64'(lat + 6), 64'd65);
        @(posedge clk);
        #1;
        chk("busy ignore no queue", {63'b0, dif.div_busy_o}, 64'd0);

        // Kill in the DONE cycle suppresses the strobe
        start(64'd20, 64'd4, F_DIVU, 1'b0);
        repeat (64) @(posedge clk);
        #1;
        dif.kill_i = 1'b1;
        #1;
        chk("kill done busy", {63'b0, dif.div_busy_o}, 64'd1);
        chk("kill done valid", {63'b0, dif.valid_res_o}, 64'd0);
        chk("kill done res", dif.div_res_o, 64'd0);
        @(posedge clk);
        #1;
        dif.kill_i = 1'b0;
        chk("kill after busy", {63'b0, dif.div_busy_o}, 64'd0);
        chk("kill after valid", {63'b0, dif.valid_res_o}, 64'd0);

        run_op("divu 5/9", 64'd5, 64'd9, F_DIVU, 1'b0, 64'd0, EO_LAT);
        run_op("remu 5/9", 64'd5, 64'd9, F_REMU, 1'b0, 64'd5, EO_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
